btb_predictor: RTL
==================

# btb_predictor

Parametrised branch target buffer with learned direction prediction for the fetch stage. Fetch presents its PC each cycle and receives a predicted next PC combinationally. Execute writes back resolved branches to allocate and train entries at run time through tags, valid bits and per-entry saturating counters. A sequenced flush invalidates every entry without a reset.

## Interface

One clock; reset is asynchronous and active-high.

Parameters:
- ENTRIES, 32, number of direct-mapped entries; power of two, ≥2. IDX = log2(ENTRIES).
- XLEN, 32, PC/target width.
- CTR_BITS, 2, saturating counter width, ≥1.
- Derived: TAG = XLEN-2-IDX. Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- fpc  in  XLEN  fetch-stage PC.
- next_pc  out  XLEN  predicted next fetch PC.
- pred_taken  out  1  prediction is taken.
- hit  out  1  fpc matches a valid entry.
- upd_valid  in  1  execute reports a resolved control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_target  in  XLEN  resolved target address.
- upd_taken  in  1  resolved direction.
- flush_req  in  1  single-cycle request to invalidate all entries.
- busy  out  1  flush in progress.

## Operation

- Storage per entry: valid, tag[TAG], target[XLEN], ctr[CTR_BITS].
- Lookup (combinational):
  - hit = !busy & valid[idx] & (tag[idx]==fpc tag).
  - pred_taken = hit & ctr[idx][MSB].
  - next_pc = pred_taken ? target[idx] : fpc+4, computed modulo 2^XLEN.
- Update on a clock edge when upd_valid & !busy, indexed by upd_pc. Update hit uses the same match rule.
  - Hit: ctr saturating +1 if taken, -1 if not taken; stays within 0..2^CTR_BITS-1. If taken, target <= upd_target.
  - Miss and taken: allocate or replace. valid=1, tag and target written, ctr = weakly taken (MSB=1, rest 0).
  - Miss and not taken: no change.
- Flush FSM, states IDLE and FLUSH, with pointer ptr[IDX]:
  - IDLE → FLUSH on flush_req; ptr <= 0.
  - Each FLUSH cycle: valid[ptr] <= 0, ptr <= ptr+1.
  - The cycle with ptr==ENTRIES-1 clears the last entry and returns to IDLE.
  - busy = (state==FLUSH).
  - flush_req while in FLUSH is ignored; the flush does not restart.
  - During FLUSH, lookups miss and updates are dropped silently.
- Reset values: all valid=0, all ctr = weakly not-taken (MSB=0, rest 1), state=IDLE, ptr=0. Tags and targets are don't-care. Resulting outputs: busy=0, hit=0, pred_taken=0, next_pc=fpc+4.

## Timing

- Lookup has zero latency; outputs follow fpc in the same cycle.
- Updates become visible to lookup after the write edge. A same-cycle lookup of the same index sees the old contents; there is no bypass.
- flush_req = 1 sampled at edge k: busy is high after edge k through edge k+ENTRIES, and low after edge k+ENTRIES. Flush lasts exactly ENTRIES cycles.
- flush_req and upd_valid at the same edge in IDLE: the update is written, then the flush clears it.
- rst asserted at any time, including mid-flush: all state returns to reset values immediately, without waiting for a clock edge. busy drops asynchronously.

## Test plan

- Cold lookup: after reset, fpc=0x28 → hit=0, pred_taken=0, next_pc=0x2C, busy=0. Wrap case: fpc=0xFFFFFFFC → next_pc=0x0.
- Allocate: update with pc=0x28, target=0x38, taken; next cycle fpc=0x28 → hit=1, pred_taken=1, next_pc=0x38. Read-during-write in the update cycle → next_pc=0x2C.
- Alias and replace (ENTRIES=32): fpc=0xA8 (index 10, other tag) → miss, next_pc=0xAC. Update pc=0xA8, target=0x100, taken; afterwards 0xA8 → 0x100 and 0x28 → miss, 0x2C.
- Counter training on 0x28:
  - Not-taken ×1 from 2 → ctr=1: hit=1, pred_taken=0, next_pc=0x2C.
  - Not-taken ×3 more → ctr saturates at 0.
  - Taken ×4 → ctr saturates at 3, prediction taken.
  - Not-taken ×1 → ctr=2, still taken.
- Flush: program 3 entries, pulse flush_req → busy high exactly 32 cycles and hit=0 throughout. An update issued mid-flush is dropped. After busy falls, all three PCs miss.
- Reset mid-flush: assert rst 10 cycles into a flush, asynchronously between edges → busy=0 before the next edge. After release, all entries miss and a new flush_req still takes 32 cycles.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and a sequenced flush that walks every entry clearing its valid bit.
module btb_predictor #(
  parameter int unsigned ENTRIES  = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fpc,
  output logic [XLEN-1:0] next_pc,
  output logic            pred_taken,
  output logic            hit,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush_req,
  output logic            busy
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TAG = XLEN - 2 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [IDX-1:0]      ptr_q, ptr_d;
  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG-1:0]      tag_q    [ENTRIES];
  logic [TAG-1:0]      tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

  logic [IDX-1:0] f_idx, u_idx;
  logic [TAG-1:0] f_tag, u_tag;
  logic           u_hit;
  logic           unused_pc_lsbs;

  assign f_idx = fpc[IDX+1:2];
  assign f_tag = fpc[XLEN-1:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX+2];
  assign unused_pc_lsbs = ^{fpc[1:0], upd_pc[1:0]};

  assign busy = (state_q == S_FLUSH);

  // Zero-latency lookup; no bypass from a same-cycle update.
  always_comb begin
    hit        = !busy && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken = hit && ctr_q[f_idx][CTR_BITS-1];
    next_pc    = pred_taken ? target_q[f_idx] : fpc + XLEN'(4);
  end

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Flush sequencing plus training/allocation from execute.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (state_q == S_IDLE) begin
      if (flush_req) begin
        state_d = S_FLUSH;
        ptr_d   = '0;
      end
    end else begin
      valid_d[ptr_q] = 1'b0;
      ptr_d          = ptr_q + IDX'(1);
      if (ptr_q == IDX'(ENTRIES - 1)) state_d = S_IDLE;
    end

    if (upd_valid && state_q == S_IDLE) begin
      if (u_hit) begin
        if (upd_taken) begin
          target_d[u_idx] = upd_target;
          if (ctr_q[u_idx] != CTR_MAX) ctr_d[u_idx] = ctr_q[u_idx] + CTR_BITS'(1);
        end else if (ctr_q[u_idx] != CTR_MIN) begin
          ctr_d[u_idx] = ctr_q[u_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule
